particle_init_ctrl: RTL and testbench

// - Sequencer for particle-memory initialisation. On a start pulse it latches a grid config and emits one

---
 rtl/particle_init_ctrl_pkg.sv | 15 +
 rtl/particle_init_ctrl_lfsr16.sv | 20 ++
 rtl/particle_init_ctrl.sv | 142 ++++++++++++++
 tb/tb_particle_init_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/particle_init_ctrl_pkg.sv
// rtl/particle_init_ctrl_pkg.sv - shared types and constants for the particle-memory init sequencer
package particle_init_ctrl_pkg;

   localparam int PWIDTH = 16;
   localparam logic [13:0] INIT_AUX = 14'b00100000000000;

   typedef struct packed {
      logic [PWIDTH-1:0] y;
      logic [PWIDTH-1:0] x;
      logic [13:0]       aux;
   } particle_t;

   typedef enum logic [1:0] {IDLE, FILL, DONE} init_state_t;

endpackage

// File: rtl/particle_init_ctrl_lfsr16.sv
// rtl/particle_init_ctrl_lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1
module lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] q
);

   localparam logic [15:0] SEED = 16'hACE1;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         q <= SEED;
      end else if (advance) begin
         q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
      end
   end

endmodule

// File: rtl/particle_init_ctrl.sv
// rtl/particle_init_ctrl.sv - grid fill sequencer emitting one particle per lattice point
// Optional jitter on x/y low bits when INIT_JITTER_EN is defined.
module particle_init_ctrl
   import particle_init_ctrl_pkg::*;
#(
   parameter int MAX_PX  = 1024,
   parameter int MAX_PY  = 1024,
   parameter int ADDR_W  = $clog2(MAX_PX*MAX_PY),
   parameter int CNT_X_W = $clog2(MAX_PX+1),
   parameter int CNT_Y_W = $clog2(MAX_PY+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_X_W-1:0] cfg_num_x,
   input  logic [CNT_Y_W-1:0] cfg_num_y,
   input  logic [PWIDTH-1:0]  cfg_step_x,
   input  logic [PWIDTH-1:0]  cfg_step_y,
   output logic               m_valid,
   input  logic               m_ready,
   output particle_t          m_data,
   output logic [ADDR_W-1:0]  m_addr,
   output logic               m_last,
   output logic               busy,
   output logic               done
);

   init_state_t        state;
   logic [CNT_X_W-1:0] nx, x_idx;
   logic [CNT_Y_W-1:0] ny, y_idx;
   logic [PWIDTH-1:0]  sx, sy, x_pos, y_pos;
   logic               fire, row_end;

   assign fire    = m_valid & m_ready;
   assign row_end = (x_idx == nx - CNT_X_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         nx      <= '0;
         ny      <= '0;
         sx      <= '0;
         sy      <= '0;
         x_idx   <= '0;
         y_idx   <= '0;
         x_pos   <= '0;
         y_pos   <= '0;
         m_addr  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  nx     <= cfg_num_x;
                  ny     <= cfg_num_y;
                  sx     <= cfg_step_x;
                  sy     <= cfg_step_y;
                  x_idx  <= '0;
                  y_idx  <= '0;
                  x_pos  <= '0;
                  y_pos  <= '0;
                  m_addr <= '0;
                  if (cfg_num_x == '0 || cfg_num_y == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state   <= FILL;
                     m_valid <= 1'b1;
                     busy    <= 1'b1;
                     m_last  <= (cfg_num_x == CNT_X_W'(1)) && (cfg_num_y == CNT_Y_W'(1));
                  end
               end
            end
            FILL: begin
               if (abort) begin
                  state   <= IDLE;
                  m_valid <= 1'b0;
                  m_last  <= 1'b0;
                  busy    <= 1'b0;
               end else if (fire) begin
                  if (m_last) begin
                     state   <= DONE;
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     m_addr <= m_addr + ADDR_W'(1);
                     if (row_end) begin
                        x_idx  <= '0;
                        x_pos  <= '0;
                        y_idx  <= y_idx + CNT_Y_W'(1);
                        y_pos  <= y_pos + sy;
                        m_last <= (nx == CNT_X_W'(1)) &&
                                  (y_idx + CNT_Y_W'(1) == ny - CNT_Y_W'(1));
                     end else begin
                        x_idx  <= x_idx + CNT_X_W'(1);
                        x_pos  <= x_pos + sx;
                        m_last <= (x_idx + CNT_X_W'(1) == nx - CNT_X_W'(1)) &&
                                  (y_idx == ny - CNT_Y_W'(1));
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INIT_JITTER_EN
   logic [15:0] lfsr_q;
   logic [15:0] jit;
   logic        start_ok;

   assign start_ok = (state == IDLE) && start && !abort;
   // Jitter only applies while a beat is presented so idle outputs keep their reset values.
   assign jit = m_valid ? lfsr_q : 16'h0000;

   lfsr16 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (start_ok),
      .advance (fire),
      .q       (lfsr_q)
   );

   assign m_data = {y_pos ^ {{(PWIDTH-4){1'b0}}, jit[7:4]},
                    x_pos ^ {{(PWIDTH-4){1'b0}}, jit[3:0]},
                    INIT_AUX};
`else
   assign m_data = {y_pos, x_pos, INIT_AUX};
`endif

endmodule

// File: tb/tb_particle_init_ctrl.sv
// tb/tb_particle_init_ctrl.sv - randomized self-checking bench for particle_init_ctrl
module tb_particle_init_ctrl;
   import particle_init_ctrl_pkg::*;

   localparam int MAX_PX  = 1024;
   localparam int MAX_PY  = 1024;
   localparam int ADDR_W  = $clog2(MAX_PX*MAX_PY);
   localparam int CNT_X_W = $clog2(MAX_PX+1);
   localparam int CNT_Y_W = $clog2(MAX_PY+1);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [CNT_X_W-1:0] cfg_num_x = '0;
   logic [CNT_Y_W-1:0] cfg_num_y = '0;
   logic [PWIDTH-1:0]  cfg_step_x = '0;
   logic [PWIDTH-1:0]  cfg_step_y = '0;
   logic               m_valid;
   logic               m_ready = 1'b0;
   particle_t          m_data;
   logic [ADDR_W-1:0]  m_addr;
   logic               m_last;
   logic               busy;
   logic               done;

   int checks = 0;
   int errors = 0;

   particle_init_ctrl #(.MAX_PX(MAX_PX), .MAX_PY(MAX_PY)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .cfg_num_x  (cfg_num_x),
      .cfg_num_y  (cfg_num_y),
      .cfg_step_x (cfg_step_x),
      .cfg_step_y (cfg_step_y),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_addr     (m_addr),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      particle_t r;
      r.x = '0; r.y = '0; r.aux = INIT_AUX;
      check({tag, "_valid"}, m_valid, 0);
      check({tag, "_last"},  m_last, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_addr"},  m_addr, 0);
      check({tag, "_data"},  m_data, r);
   endtask

   // mode: 0 always ready, 1 ready toggles 1010.., 2 random ready
   task automatic run(input int nx, input int ny, input logic [PWIDTH-1:0] sx,
                      input logic [PWIDTH-1:0] sy, input int mode, input int abort_after,
                      input bit poke);
      particle_t eq[$];
      int        ea[$];
      bit        el[$];
      particle_t p, hd;
      logic [15:0] j;
      logic [ADDR_W-1:0] ha;
      bit        hl, stall, fin;
      int        nb, fires, dones, last_fire, done_cyc, abort_phase;

      j = 16'hACE1;
      for (int yi = 0; yi < ny; yi++) begin
         for (int xi = 0; xi < nx; xi++) begin
            p.x   = PWIDTH'(xi * sx);
            p.y   = PWIDTH'(yi * sy);
            p.aux = INIT_AUX;
`ifdef INIT_JITTER_EN
            p.x[3:0] = p.x[3:0] ^ j[3:0];
            p.y[3:0] = p.y[3:0] ^ j[7:4];
            j = {j[14:0], j[15] ^ j[13] ^ j[12] ^ j[10]};
`endif
            eq.push_back(p);
            ea.push_back(yi * nx + xi);
            el.push_back((xi == nx - 1) && (yi == ny - 1));
         end
      end
      nb = nx * ny;

      @(negedge clk);
      cfg_num_x  = CNT_X_W'(nx);
      cfg_num_y  = CNT_Y_W'(ny);
      cfg_step_x = sx;
      cfg_step_y = sy;
      start = 1'b1;
      abort = 1'b0;
      m_ready = 1'b0;
      fires = 0; dones = 0; last_fire = -1; done_cyc = -1; abort_phase = 0;
      stall = 0; fin = 0; hd = '0; ha = '0; hl = 0;

      for (int c = 0; c < 2000 && !fin; c++) begin
         @(negedge clk);
         start = poke && (c == 2);
         // live config changes after the start must have no effect
         cfg_num_x  = CNT_X_W'($urandom);
         cfg_num_y  = CNT_Y_W'($urandom);
         cfg_step_x = PWIDTH'($urandom);
         cfg_step_y = PWIDTH'($urandom);
         if (c == 0) check("first_valid", m_valid, nb > 0);
         if (abort_phase == 1) begin
            abort = 1'b1;
            m_ready = 1'($urandom);
            abort_phase = 2;
         end else if (abort_phase == 2) begin
            abort = 1'b0;
            check("abort_valid", m_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_last", m_last, 0);
            abort_phase = 3;
         end else if (abort_phase == 3) begin
            check("abort_nodone", done, 0);
            fin = 1;
         end else begin
            if (done) begin
               dones++;
               done_cyc = c;
               check("done_time", c, (nb > 0) ? last_fire + 1 : 0);
            end
            if (dones > 0 && c > done_cyc) begin
               check("idle_valid", m_valid, 0);
               fin = 1;
            end
            check("busy", busy, m_valid);
            if (stall) begin
               check("hold_data", m_data, hd);
               check("hold_addr", m_addr, ha);
               check("hold_last", m_last, hl);
            end
            case (mode)
               0:       m_ready = 1'b1;
               1:       m_ready = (c % 2) == 0;
               default: m_ready = 1'($urandom);
            endcase
            if (m_valid && m_ready) begin
               if (fires < nb) begin
                  check("beat_data", m_data, eq[fires]);
                  check("beat_addr", m_addr, ea[fires]);
                  check("beat_last", m_last, el[fires]);
               end
               fires++;
               last_fire = c;
               if (fires == abort_after) abort_phase = 1;
            end
            stall = m_valid && !m_ready;
            hd = m_data; ha = m_addr; hl = m_last;
         end
      end
      if (!fin) check("timeout", 0, 1);
      check("beats", fires, (abort_after > 0) ? abort_after : nb);
      check("dones", dones, (abort_after > 0) ? 0 : 1);
      start = 1'b0;
      abort = 1'b0;
      m_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      run(4, 2, 16, 32, 0, 0, 0);
      run(4, 2, 16, 32, 1, 0, 0);
      run(0, 3, 5, 7, 0, 0, 0);
      run(2, 0, 5, 7, 0, 0, 0);
      run(1, 1, 9, 9, 0, 0, 0);
      run(3, 1, PWIDTH'(1) << (PWIDTH - 1), 0, 0, 0, 0);
      run(4, 2, 16, 32, 0, 3, 0);
      run(4, 2, 16, 32, 0, 0, 0);
      run(4, 2, 16, 32, 0, 0, 1);

      // start and abort together from IDLE
      @(negedge clk);
      cfg_num_x = 4; cfg_num_y = 2; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("race_valid", m_valid, 0);
      check("race_busy", busy, 0);
      @(negedge clk);
      check("race_done", done, 0);

      // reset in the middle of a fill
      cfg_num_x = 4; cfg_num_y = 2; cfg_step_x = 16; cfg_step_y = 32;
      start = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("midrst");
      rst = 1'b0;
      m_ready = 1'b0;
      run(4, 2, 16, 32, 2, 0, 0);

      for (int i = 0; i < 8; i++) begin
         run($urandom_range(0, 5), $urandom_range(0, 4), PWIDTH'($urandom), PWIDTH'($urandom),
             2, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
